// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encodings and a
// helper that sizes the beat counter.
package word_serializer_pkg;

  // 2'd3 is unused; the FSM treats it as illegal and falls back to IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Counter width is ceil(log2(width)), but at least one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/word_serializer_shift_register.sv
// Shadow register for the serializer: parallel load, one-bit zero-fill
// shift per enable, and the bit currently at the transmit end.
module shift_register
  import word_serializer_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_head
);

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] w_shifted;

  // Shifted image of the shadow: left for MSB-first, right for LSB-first,
  // with a zero entering at the far end.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_left
        if (gi == 0) begin : g_fill
          assign w_shifted[gi] = 1'b0;
        end else begin : g_move
          assign w_shifted[gi] = r_shadow[gi-1];
        end
      end else begin : g_right
        if (gi == WIDTH - 1) begin : g_fill
          assign w_shifted[gi] = 1'b0;
        end else begin : g_move
          assign w_shifted[gi] = r_shadow[gi+1];
        end
      end
    end
  endgenerate

  // Load has priority; shift only advances on an accepted beat, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (i_load) begin
      r_shadow <= i_data;
    end else if (i_shift) begin
      r_shadow <= w_shifted;
    end
  end

  assign o_head = MSB_FIRST ? r_shadow[WIDTH-1] : r_shadow[0];

endmodule

// File: rtl/word_serializer.sv
// Word serializer: captures a parallel word on start and sends it one bit
// per accepted valid/ready beat, then pulses done for one cycle.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             w_load;
  logic             w_beat;
  logic             w_head;

  shift_register #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift_register (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_shift(w_beat),
    .i_data (in),
    .o_head (w_head)
  );

  // State and beat counter registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // Next-state, counter update and output decode of the registered state.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_load       = 1'b0;
    w_beat       = 1'b0;
    ser_out      = 1'b0;
    ser_valid    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_count_next = '0;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_out   = w_head;
        if (ser_ready) begin
          w_beat       = 1'b1;
          w_count_next = r_count + CNT_W'(1);
          if (r_count == LAST_COUNT) begin
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        done         = 1'b1;
        busy         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: one MSB-first and one LSB-first
// instance, driven through a linear sequence of hand-checked steps.
module tb_word_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] m_in;
  logic        m_start;
  logic        m_ready;
  logic        m_out, m_valid, m_busy, m_done;
  logic [15:0] l_in;
  logic        l_start;
  logic        l_ready;
  logic        l_out, l_valid, l_busy, l_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_bits;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .in(m_in), .start(m_start), .ser_ready(m_ready),
    .ser_out(m_out), .ser_valid(m_valid), .busy(m_busy), .done(m_done)
  );

  word_serializer #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in(l_in), .start(l_start), .ser_ready(l_ready),
    .ser_out(l_out), .ser_valid(l_valid), .busy(l_busy), .done(l_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // {ser_out, ser_valid, busy, done}
  function automatic logic [3:0] msb_flags();
    return {m_out, m_valid, m_busy, m_done};
  endfunction

  function automatic logic [3:0] lsb_flags();
    return {l_out, l_valid, l_busy, l_done};
  endfunction

  initial begin
    reset = 1'b1; m_in = '0; m_start = 0; m_ready = 0;
    l_in = '0; l_start = 0; l_ready = 0;

    // 1: reset for two clocks, then idle with ready high
    tick(); tick();
    check("reset_msb", msb_flags(), 4'b0000);
    check("reset_lsb", lsb_flags(), 4'b0000);
    reset = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("idle_%0d", i), msb_flags(), 4'b0000);
    end

    // 2: 0xA00C MSB first, ready held high
    exp_bits = 16'b1010_0000_0000_1100;
    m_in = 16'hA00C; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2_bit%0d", i), msb_flags(), {exp_bits[15-i], 3'b110});
      tick();
    end
    check("t2_done", msb_flags(), 4'b0011);
    tick();
    check("t2_idle", msb_flags(), 4'b0000);

    // 3: same word, ready toggles starting low in the first shift cycle
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      m_ready = (c % 2 == 0);
      check($sformatf("t3_cyc%0d", c), msb_flags(), {exp_bits[15-((c-1)/2)], 3'b110});
      tick();
    end
    m_ready = 1'b1;
    check("t3_done", msb_flags(), 4'b0011);
    tick();
    check("t3_idle", msb_flags(), 4'b0000);

    // 4: in changes and start pulses during SHIFT; only 0x0030 goes out
    exp_bits = 16'b0000_0000_0011_0000;
    m_in = 16'h0030; m_start = 1'b1;
    tick();
    m_start = 1'b0; m_in = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      m_start = (i == 3);
      check($sformatf("t4_bit%0d", i), msb_flags(), {exp_bits[15-i], 3'b110});
      tick();
    end
    m_start = 1'b0;
    check("t4_done", msb_flags(), 4'b0011);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t4_idle%0d", i), msb_flags(), 4'b0000);
    end

    // 5: 0x2000, reset after five beats, then a fresh 0x0070
    exp_bits = 16'b0010_0000_0000_0000;
    m_in = 16'h2000; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5_bit%0d", i), msb_flags(), {exp_bits[15-i], 3'b110});
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_abort", msb_flags(), 4'b0000);
    tick();
    check("t5_nodone", msb_flags(), 4'b0000);
    exp_bits = 16'b0000_0000_0111_0000;
    m_in = 16'h0070; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t5b_bit%0d", i), msb_flags(), {exp_bits[15-i], 3'b110});
      tick();
    end
    check("t5b_done", msb_flags(), 4'b0011);

    // 6: LSB first 0x000F, then back-to-back 0x8001 right after DONE
    exp_bits = 16'h000F;
    l_ready = 1'b1; l_in = 16'h000F; l_start = 1'b1;
    tick();
    l_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t6_bit%0d", i), lsb_flags(), {(i < 4) ? 1'b1 : 1'b0, 3'b110});
      tick();
    end
    check("t6_done", lsb_flags(), 4'b0011);
    tick();
    check("t6_idle", lsb_flags(), 4'b0000);
    l_in = 16'h8001; l_start = 1'b1;
    tick();
    l_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t6b_bit%0d", i), lsb_flags(), {(i == 0 || i == 15) ? 1'b1 : 1'b0, 3'b110});
      tick();
    end
    check("t6b_done", lsb_flags(), 4'b0011);
    tick();
    check("t6b_idle", lsb_flags(), 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
